// File: rtl/ff_bank_multimode.sv
// Multi-mode flip-flop bank: each bit acts as a D, T, JK or SR flip-flop chosen by a shared mode.
// Also reports changed bits, a sticky S=R=1 error flag and a saturating toggle count.
module ff_bank_multimode #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RST_VAL = '0,
  parameter int unsigned           CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] chg,
  output logic             sr_err,
  output logic [CNT_W-1:0] tgl_cnt
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  mode_e            mode_s;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] diff;
  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_next;
  logic             err_set;

  always_comb begin
    mode_s = mode_e'(mode);
    q_next = q;
    if (clr) begin
      q_next = RST_VAL;
    end else if (en) begin
      unique case (mode_s)
        MODE_D:  q_next = a;
        MODE_T:  q_next = q ^ a;
        MODE_JK: q_next = (a & ~q) | (~b & q);
        // bits with S=R=1 keep their value instead of taking the forbidden input
        MODE_SR: q_next = (((q | a) & ~b) & ~(a & b)) | (q & a & b);
        default: q_next = q;
      endcase
    end
  end

  always_comb begin
    diff = q ^ q_next;
    pop  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + {{CNT_W{1'b0}}, diff[i]};
    end
    sum      = {1'b0, tgl_cnt} + pop;
    cnt_next = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
  end

  always_comb begin
    err_set = ~clr & en & (mode_s == MODE_SR) & (|(a & b));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= RST_VAL;
      chg     <= '0;
      sr_err  <= 1'b0;
      tgl_cnt <= '0;
    end else begin
      q       <= q_next;
      chg     <= diff;
      sr_err  <= err_set | (sr_err & ~err_clr);
      tgl_cnt <= cnt_clr ? '0 : cnt_next;
    end
  end

endmodule

// File: doc/ff_bank_multimode.md
# ff_bank_multimode

Parametrised register bank in which every bit is a flip-flop whose type (D, T, JK or SR) is selected at run time by a shared mode input. The bank also reports which bits changed on the last update and keeps a saturating count of bit toggles. It is the general-purpose successor to the single-bit T-from-D flip-flop and serves as a drop-in state-holding primitive for counters, flag registers and control logic.

## Interface
- WIDTH, 8, number of flip-flop bits in the bank.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q by reset and by synchronous clear.
- CNT_W, 16, width of the toggle counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  update enable.
- clr  in  1  synchronous clear of q to RST_VAL.
- mode  in  2  flip-flop type: 00 D, 01 T, 10 JK, 11 SR.
- a  in  WIDTH  per-bit D / T / J / S input.
- b  in  WIDTH  per-bit K / R input; ignored in D and T modes.
- err_clr  in  1  clears sr_err.
- cnt_clr  in  1  clears tgl_cnt.
- q  out  WIDTH  flip-flop outputs.
- chg  out  WIDTH  bits of q that changed at the last rising edge.
- sr_err  out  1  sticky flag: S=R=1 was applied to at least one bit.
- tgl_cnt  out  CNT_W  saturating count of bit changes.

## Operation
- Reset (rst=0, asynchronous): q=RST_VAL, chg=0, sr_err=0, tgl_cnt=0. Reset holds while rst=0 and overrides every other input. Release is synchronous to clk at the integration level.
- Priority at each edge: rst > clr > en.
- clr=1: q_next=RST_VAL, regardless of en and mode.
- clr=0, en=1: q_next is computed per bit from mode:
  - D: q_next=a.
  - T: q_next=q^a.
  - JK: q_next=(a&~q)|(~b&q). This gives hold, set, reset and toggle.
  - SR: q_next=(q|a)&~b for bits where !(a&b). Bits with a=b=1 hold their value.
- clr=0, en=0: q holds.
- chg is registered as chg<=q^q_next on every edge. It is 0 when the bank holds.
- tgl_cnt:
  - Each edge adds popcount(q^q_next), which ranges 0..WIDTH.
  - Changes caused by clr are counted.
  - Changes caused by async reset are not counted.
  - The counter saturates at 2^CNT_W-1 and never wraps.
  - Adder width is CNT_W+1 before the saturation compare.
- cnt_clr=1: tgl_cnt<=0. This wins over a concurrent increment, and that increment is discarded.
- sr_err:
  - Set at an edge where clr=0, en=1, mode=11 and |(a&b) is true.
  - Cleared by err_clr=1 at an edge.
  - Set wins when set and clear occur in the same cycle.
  - Never set in other modes.
- A mode change takes effect on the next edge. The bank holds no mode history.

## Timing
- q, chg, sr_err and tgl_cnt are all registered and update together on the same rising edge. Latency from input to q is one cycle.
- chg and tgl_cnt describe the edge that produced the current q. They never lag by an extra cycle.
- No combinational path runs from the inputs to the outputs.
- When rst is asserted mid-operation, all outputs go to their reset values immediately, without waiting for clk. The first edge after release evaluates normally.

## Test plan
All scenarios use WIDTH=8 and RST_VAL=0 unless stated.

1. Reset: drive rst=0 mid-cycle with q=0x5A. q=0x00, chg=0, sr_err=0 and tgl_cnt=0 must appear before the next edge.
2. T mode: from q=0x00, apply mode=01, a=0xFF, en=1 for 3 edges. q must read 0xFF, 0x00, 0xFF, chg must be 0xFF each cycle, and tgl_cnt must reach 24.
3. JK mode: from q=0xF0, apply mode=10, a=0xCC, b=0xAA for one edge. Required: q=0x5C, chg=0xAC, tgl_cnt incremented by 4.
4. SR error:
   - From q=0x0F, apply mode=11, a=0x81, b=0x01. Required: q=0x8F, chg=0x80, sr_err=1.
   - Next edge, err_clr=1 with a=0x01, b=0x01: sr_err stays 1 (set wins).
   - Following edge, err_clr=1 with a=b=0: sr_err=0.
5. Saturation (CNT_W=4): from q=0x00, apply T mode with a=0xFF. After the first edge tgl_cnt=8, and after the second edge tgl_cnt=15. It stays at 15 on further toggles until cnt_clr=1, which gives 0 even with a toggle on the same edge.
6. Priority:
   - clr=1, en=1, mode=00, a=0x55 from q=0x0F: q=0x00, chg=0x0F, tgl_cnt incremented by 4.
   - en=0, clr=0: q holds, chg=0x00, tgl_cnt unchanged.
